// File: rtl/nmr_bstrm_pkg.sv
// nmr_bstrm_pkg: shared state encoding, instruction layout and command bits for the pulse-sequence engine
package nmr_bstrm_pkg;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_IDLY, S_PLS, S_EDLY, S_FLOW, S_FIN} state_t;
  localparam int CMD_LOOP_END = 0;
  localparam int CMD_LOOP_START = 1;
  localparam int CMD_END = 2;
  localparam int F_CMD_LSB = 0;
  localparam int F_MASK_LSB = 8;
  localparam int F_LOOP_LSB = 16;
  localparam int F_IDLY_LSB = 32;
  localparam int F_PLS_LSB = 64;
  localparam int F_EDLY_LSB = 96;
  typedef struct packed {
    logic [31:0] edly;
    logic [31:0] pls;
    logic [31:0] idly;
    logic [15:0] loop;
    logic [7:0]  mask;
    logic [7:0]  cmd;
  } instr_t;
endpackage

// File: rtl/nmr_bstrm_multich_seq_if.sv
// nmr_bstrm_multich_seq_if: instruction SRAM port between the sequencer and the on-chip RAM
interface nmr_bstrm_multich_seq_if #(
  parameter int AW = 8,
  parameter int DW = 128,
  parameter int BW = 16
);
  logic [AW-1:0] addr;
  logic          cs;
  logic          clken;
  logic          wr;
  logic [DW-1:0] rd_dat;
  logic [DW-1:0] wr_dat;
  logic [BW-1:0] byteen;
  modport master (output addr, cs, clken, wr, wr_dat, byteen, input rd_dat);
  modport slave (input addr, cs, clken, wr, wr_dat, byteen, output rd_dat);
endinterface

// File: rtl/nmr_bstrm_loop_stack.sv
// nmr_bstrm_loop_stack: LIFO of {return address, remaining count} for nested sequence loops
module nmr_bstrm_loop_stack #(
  parameter int DEPTH = 4,
  parameter int AW = 8,
  parameter int LW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          dec,
  input  logic          clr,
  input  logic [AW-1:0] push_addr,
  input  logic [LW-1:0] push_cnt,
  output logic [AW-1:0] top_addr,
  output logic [LW-1:0] top_cnt,
  output logic          full,
  output logic          empty
);
  localparam int SPW = $clog2(DEPTH + 1);
  logic [SPW-1:0] sp, top_i;
  logic [AW-1:0] addr_mem [1 << SPW];
  logic [LW-1:0] cnt_mem [1 << SPW];
  assign top_i = sp - SPW'(1);
  assign top_addr = addr_mem[top_i];
  assign top_cnt = cnt_mem[top_i];
  assign full = sp == SPW'(DEPTH);
  assign empty = sp == '0;
  always_ff @(posedge clk) begin
    if (rst || clr) sp <= '0;
    else if (push && !full) begin
      addr_mem[sp] <= push_addr;
      cnt_mem[sp] <= push_cnt;
      sp <= sp + SPW'(1);
    end else if (pop && !empty) sp <= sp - SPW'(1);
    else if (dec && !empty) cnt_mem[top_i] <= cnt_mem[top_i] - LW'(1);
  end
endmodule

// File: rtl/nmr_bstrm_multich_seq.sv
// nmr_bstrm_multich_seq: SRAM-programmed multichannel NMR pulse-sequence engine with nested loops
module nmr_bstrm_multich_seq
  import nmr_bstrm_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int IDLY_WIDTH = 32,
  parameter int PLS_WIDTH = 32,
  parameter int EDLY_WIDTH = 32,
  parameter int LOOP_WIDTH = 16,
  parameter int LOOP_DEPTH = 4,
  parameter int SRAM_ADDR_WIDTH = 8,
  parameter int SRAM_DAT_WIDTH = 128,
  parameter int SRAM_BYTEEN_WIDTH = 16,
  parameter int SRAM_RD_LAT = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [SRAM_ADDR_WIDTH-1:0] start_addr,
  input  logic                       abort,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [NUM_CH-1:0]          out,
  nmr_bstrm_multich_seq_if.master    sram
);
  localparam int CW0 = IDLY_WIDTH > PLS_WIDTH ? IDLY_WIDTH : PLS_WIDTH;
  localparam int CW = CW0 > EDLY_WIDTH ? CW0 : EDLY_WIDTH;
  localparam int WW = $clog2(SRAM_RD_LAT + 1);
  state_t state, nx_state;
  instr_t ir, wi;
  logic [CW-1:0] cnt, nx_cnt;
  logic [WW-1:0] wcnt;
  logic [SRAM_ADDR_WIDTH-1:0] addr, top_addr;
  logic [LOOP_WIDTH-1:0] top_cnt, lp_cnt;
  logic start_q, cs, full, empty, is_end, is_le, is_ls, in_flow, push, pop, dec, flow_err, unused_bits;
  assign sram.addr = addr;
  assign sram.cs = cs;
  assign sram.clken = cs;
  assign sram.wr = 1'b0;
  assign sram.wr_dat = SRAM_DAT_WIDTH'(0);
  assign sram.byteen = {SRAM_BYTEEN_WIDTH{1'b1}};
  assign unused_bits = ^{ir.cmd[7:3], ir.mask};
  // Next timed phase skips any phase whose length field is zero
  always_comb begin
    wi = state == S_WAIT ? instr_t'(sram.rd_dat) : ir;
    nx_state = (state == S_WAIT && |wi.idly[IDLY_WIDTH-1:0]) ? S_IDLY :
               ((state == S_WAIT || state == S_IDLY) && |wi.pls[PLS_WIDTH-1:0]) ? S_PLS :
               (state != S_EDLY && |wi.edly[EDLY_WIDTH-1:0]) ? S_EDLY : S_FLOW;
    nx_cnt = nx_state == S_IDLY ? CW'(wi.idly[IDLY_WIDTH-1:0]) :
             nx_state == S_PLS ? CW'(wi.pls[PLS_WIDTH-1:0]) : CW'(wi.edly[EDLY_WIDTH-1:0]);
    is_end = ir.cmd[CMD_END];
    is_le = ir.cmd[CMD_LOOP_END] & ~is_end;
    is_ls = ir.cmd[CMD_LOOP_START] & ~is_end & ~ir.cmd[CMD_LOOP_END];
    in_flow = state == S_FLOW && !abort;
    lp_cnt = ir.loop[LOOP_WIDTH-1:0] == '0 ? LOOP_WIDTH'(1) : ir.loop[LOOP_WIDTH-1:0];
    push = in_flow && is_ls && !full;
    pop = in_flow && is_le && !empty && top_cnt <= LOOP_WIDTH'(1);
    dec = in_flow && is_le && !empty && top_cnt > LOOP_WIDTH'(1);
    flow_err = (is_ls && full) || (is_le && empty);
  end
  nmr_bstrm_loop_stack #(.DEPTH(LOOP_DEPTH), .AW(SRAM_ADDR_WIDTH), .LW(LOOP_WIDTH)) u_stack (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .dec(dec), .clr(state == S_FIN),
    .push_addr(addr + SRAM_ADDR_WIDTH'(1)), .push_cnt(lp_cnt),
    .top_addr(top_addr), .top_cnt(top_cnt), .full(full), .empty(empty)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      ir <= '0;
      cnt <= '0;
      wcnt <= '0;
      addr <= '0;
      start_q <= 1'b0;
      cs <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      out <= '0;
    end else begin
      start_q <= start;
      cs <= 1'b0;
      done <= 1'b0;
      out <= (state == S_PLS && !abort) ? ir.mask[NUM_CH-1:0] : '0;
      if (abort && state != S_IDLE && state != S_FIN) begin
        state <= S_FIN;
        done <= 1'b1;
        busy <= 1'b0;
      end else case (state)
        S_IDLE: if (start && !start_q && !abort) begin
          state <= S_FETCH;
          addr <= start_addr;
          busy <= 1'b1;
          err <= 1'b0;
          cs <= 1'b1;
        end
        S_FETCH: begin
          state <= S_WAIT;
          wcnt <= WW'(SRAM_RD_LAT - 1);
        end
        S_WAIT: if (wcnt <= WW'(1)) begin
          ir <= wi;
          state <= nx_state;
          cnt <= nx_cnt;
        end else wcnt <= wcnt - WW'(1);
        S_IDLY, S_PLS, S_EDLY: if (cnt <= CW'(1)) begin
          state <= nx_state;
          cnt <= nx_cnt;
        end else cnt <= cnt - CW'(1);
        S_FLOW: if (is_end || flow_err) begin
          state <= S_FIN;
          done <= 1'b1;
          busy <= 1'b0;
          err <= err | flow_err;
        end else begin
          state <= S_FETCH;
          cs <= 1'b1;
          addr <= dec ? top_addr : addr + SRAM_ADDR_WIDTH'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
